// File: rtl/fifo_4.sv
`default_nettype none
// ============================================================================
// Module   : fifo_4
// Brief    : Four-entry first-word-fall-through synchronous FIFO with clear.
// Revision : 1.0
// ============================================================================
module fifo_4 #(
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [dw-1:0] din,
    input  logic          we,
    output logic [dw-1:0] dout,
    input  logic          re,
    output logic          full,
    output logic          empty
);

    logic [dw-1:0] mem_q [0:3];
    logic [dw-1:0] mem_d [0:3];
    logic [1:0]    wp_q, wp_d;
    logic [1:0]    rp_q, rp_d;
    logic [2:0]    count_q, count_d;
    logic          w_pop;
    logic          w_push;

    assign empty = (count_q == 3'd0);
    assign full  = (count_q == 3'd4);
    assign dout  = mem_q[rp_q];

    // A write into a full FIFO is accepted only when the same edge frees the head slot.
    assign w_pop  = re && !empty;
    assign w_push = we && (!full || w_pop);

    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (!clr) begin
            if (w_push) begin
                mem_d[wp_q] = din;
                wp_d        = wp_q + 2'd1;
            end
            if (w_pop) begin
                rp_d = rp_q + 2'd1;
            end
            count_d = count_q + {2'b00, w_push} - {2'b00, w_pop};
        end else begin
            wp_d    = 2'd0;
            rp_d    = 2'd0;
            count_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q    <= 2'd0;
            rp_q    <= 2'd0;
            count_q <= 3'd0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; a write during reset is harmless because no pointer advances.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_4
// Brief    : Directed scoreboard bench for fifo_4.
// Revision : 1.0
// ============================================================================
module tb_fifo_4;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [7:0] din;
    logic       we;
    logic [7:0] dout;
    logic       re;
    logic       full;
    logic       empty;

    int         tests;
    int         fails;
    logic [7:0] sb[$];

    fifo_4 #(.dw(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .din   (din),
        .we    (we),
        .dout  (dout),
        .re    (re),
        .full  (full),
        .empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_empty"}, {31'd0, empty}, {31'd0, sb.size() == 0});
        chk({tag, "_full"},  {31'd0, full},  {31'd0, sb.size() == 4});
    endtask

    task automatic peek(input string tag);
        chk_flags(tag);
        if (sb.size() > 0) chk({tag, "_head"}, {24'd0, dout}, {24'd0, sb[0]});
    endtask

    // One clock with the given we/re/din; the model mirrors the FIFO rules, not the RTL.
    task automatic cyc(input string tag, input logic w, input logic r, input logic [7:0] d);
        bit was_full;
        bit popped;
        chk_flags(tag);
        if (r && sb.size() > 0) chk({tag, "_dout"}, {24'd0, dout}, {24'd0, sb[0]});
        we  = w;
        re  = r;
        din = d;
        @(posedge clk);
        #1;
        was_full = (sb.size() == 4);
        popped   = r && (sb.size() > 0);
        if (popped) void'(sb.pop_front());
        if (w && (!was_full || popped)) sb.push_back(d);
        we  = 1'b0;
        re  = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        clr   = 1'b0;
        we    = 1'b1;
        re    = 1'b0;
        din   = 8'hAA;

        // Reset held two cycles while writing: nothing may be stored.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        we  = 1'b0;
        peek("reset");

        // Fill and drain
        cyc("fill", 1'b1, 1'b0, 8'h11);
        peek("fwft");
        cyc("fill", 1'b1, 1'b0, 8'h22);
        cyc("fill", 1'b1, 1'b0, 8'h33);
        cyc("fill", 1'b1, 1'b0, 8'h44);
        peek("full4");
        repeat (4) cyc("drain", 1'b0, 1'b1, 8'h00);
        peek("drained");

        // Overflow: 55 dropped, read on empty ignored
        cyc("ovf", 1'b1, 1'b0, 8'h11);
        cyc("ovf", 1'b1, 1'b0, 8'h22);
        cyc("ovf", 1'b1, 1'b0, 8'h33);
        cyc("ovf", 1'b1, 1'b0, 8'h44);
        cyc("ovf_w55", 1'b1, 1'b0, 8'h55);
        peek("ovf_after");
        repeat (4) cyc("ovf_rd", 1'b0, 1'b1, 8'h00);
        cyc("udf_rd", 1'b0, 1'b1, 8'h00);
        peek("udf_after");
        cyc("w66", 1'b1, 1'b0, 8'h66);
        cyc("r66", 1'b0, 1'b1, 8'h00);
        peek("r66_after");

        // Simultaneous with 2 entries
        cyc("sim2", 1'b1, 1'b0, 8'hA1);
        cyc("sim2", 1'b1, 1'b0, 8'hA2);
        cyc("sim2_wr", 1'b1, 1'b1, 8'hA3);
        peek("sim2_after");
        repeat (2) cyc("sim2_rd", 1'b0, 1'b1, 8'h00);
        peek("sim2_empty");

        // Simultaneous while full
        for (int i = 0; i < 4; i++) cyc("simf", 1'b1, 1'b0, 8'hB0 + 8'(i));
        cyc("simf_wr", 1'b1, 1'b1, 8'hB4);
        peek("simf_after");
        repeat (4) cyc("simf_rd", 1'b0, 1'b1, 8'h00);

        // Simultaneous while empty: write only
        cyc("sime_wr", 1'b1, 1'b1, 8'h77);
        peek("sime_after");
        cyc("sime_rd", 1'b0, 1'b1, 8'h00);

        // Clear with 3 entries, concurrent write must be dropped
        for (int i = 0; i < 3; i++) cyc("clr_fill", 1'b1, 1'b0, 8'hC0 + 8'(i));
        clr = 1'b1;
        we  = 1'b1;
        din = 8'h99;
        @(posedge clk);
        #1;
        clr = 1'b0;
        we  = 1'b0;
        sb.delete();
        peek("clr_after");
        cyc("clr_w", 1'b1, 1'b0, 8'hD0);
        cyc("clr_w", 1'b1, 1'b0, 8'hD1);
        repeat (2) cyc("clr_rd", 1'b0, 1'b1, 8'h00);
        peek("clr_empty");

        // Wrap-around: write-2/read-2 rounds
        for (int r = 0; r < 10; r++) begin
            cyc("wrap_w", 1'b1, 1'b0, 8'(2 * r));
            cyc("wrap_w", 1'b1, 1'b0, 8'(2 * r + 1));
            cyc("wrap_r", 1'b0, 1'b1, 8'h00);
            cyc("wrap_r", 1'b0, 1'b1, 8'h00);
        end
        peek("wrap_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_4.md
# fifo_4

Four-entry, first-word-fall-through synchronous FIFO with parameterised data width. It is the buffering element used on both sides of the SPI master core: a write buffer between the bus and the shift register, and a read buffer for received bytes. It provides full/empty status and a synchronous clear in addition to reset.

## Interface
- dw, default 8: data width in bits.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low (sampled on rising clk edge).
- clr  input  1  synchronous clear, active-high; empties FIFO.
- din  input  dw  write data.
- we  input  1  write enable; pushes din on rising clk.
- dout  output  dw  data at head of FIFO (combinational from storage).
- re  input  1  read enable; pops head entry on rising clk.
- full  output  1  high when 4 entries held.
- empty  output  1  high when 0 entries held.

## Operation
- Storage: 4 × dw registers, write pointer wp (2 bits), read pointer rp (2 bits), occupancy tracked with a guard bit or 3-bit count (0..4).
- Pointers wrap modulo 4 (3 -> 0).
- Priority per clock edge: rst low > clr high > we/re.
- rst low: wp=0, rp=0, count=0; storage contents not reset (don't-care).
- clr high (rst high): same as reset for pointers/count; we and re ignored that cycle.
- Write (we=1, not full): mem[wp] <= din, wp <= wp+1, count+1.
- Write while full, no read: discarded; storage, wp, count unchanged.
- Read (re=1, not empty): rp <= rp+1, count-1.
- Read while empty: ignored; pointers unchanged.
- Simultaneous we and re, 1..3 entries: both performed, count unchanged.
- Simultaneous we and re, full: both performed (pop head, push din into freed slot), stays full.
- Simultaneous we and re, empty: write performed, read ignored; count becomes 1.
- dout = mem[rp] at all times; value undefined while empty (holds stale data).
- empty = (count==0); full = (count==4); both derived combinationally from registered state, never both high.

## Timing
- After reset: empty=1, full=0; dout undefined.
- Write latency: data written at edge N is visible on dout after edge N if FIFO was empty (first-word-fall-through); empty drops after edge N.
- Read: dout presents head entry before the edge; after the edge with re=1, dout shows next entry.
- full rises after the edge that accepts the 4th write; falls after the edge that accepts a read with no write.
- Flags and dout change only after clock edges (plus combinational path from storage/pointers); no input-to-output combinational path.
- clr/rst mid-operation: at that edge all entries discarded; empty=1, full=0 next cycle, regardless of we/re.

## Test plan
- Reset: hold rst=0 two cycles with we=1, din=8'hAA -> empty=1, full=0 after release, no entry stored.
- Fill and drain: write 8'h11,8'h22,8'h33,8'h44 -> full=1 after 4th edge; read 4 times -> dout sequence 11,22,33,44, empty=1 after last read.
- Overflow: with FIFO full (11..44), write 8'h55 -> still full, reads return 11,22,33,44 (55 dropped); extra read when empty -> empty stays 1, later write 8'h66 reads back 66.
- Simultaneous: with 2 entries (A1,A2), we+re with din=8'hA3 -> count stays 2, dout becomes A2 then A3; when full, we+re -> full stays 1, order preserved; when empty, we+re din=8'h77 -> empty=0, dout=77.
- Clear: with 3 entries, assert clr with we=1 din=8'h99 -> empty=1 next cycle, 99 not stored; following writes start from pointer 0 and read back correctly.
- Wrap-around: 10 rounds of write-2/read-2 with incrementing data -> read data equals written data in order, flags correct across pointer wrap.
